// File: rtl/instr_fetch_seq_if.sv
// instr_fetch_seq_if: memory, decode and redirect signals of the fetch sequencer
interface instr_fetch_seq_if #(
  parameter int ADDR_W      = 19,
  parameter int BYTE_W      = 8,
  parameter int INSTR_BYTES = 4
);
  localparam int IW = INSTR_BYTES * BYTE_W;
  logic              fetch_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTE_W-1:0] mem_rdata;
  logic [IW-1:0]     instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              exec_done;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halted;
  modport master (
    input  fetch_en, mem_rdata, exec_done, redirect_valid, redirect_pc,
    output mem_addr, instr, instr_pc, instr_valid, halted
  );
  modport slave (
    output fetch_en, mem_rdata, exec_done, redirect_valid, redirect_pc,
    input  mem_addr, instr, instr_pc, instr_valid, halted
  );
endinterface

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: byte-serial instruction fetch with valid/done handshake, redirect and halt parking
module instr_fetch_seq #(
  parameter int              ADDR_W      = 19,
  parameter int              BYTE_W      = 8,
  parameter int              INSTR_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter bit              HALT_EN     = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_seq_if.master bus
);
  localparam int IW    = INSTR_BYTES * BYTE_W;
  localparam int CNT_W = $clog2(INSTR_BYTES + 1);
  typedef enum logic [1:0] {S_FETCH, S_DECIDE, S_WAIT, S_HALT} state_t;
  state_t            r_state, w_state_n;
  logic [ADDR_W-1:0] r_pc, w_pc_n;
  logic [CNT_W-1:0]  r_cnt, w_cnt_n;
  logic [IW-1:0]     r_instr, w_instr_n;
  logic              r_valid, w_valid_n;
  logic              r_halted, w_halted_n;
  logic [IW-1:0]     w_shift;
  logic              w_last;
  assign w_shift          = (r_instr << BYTE_W) | IW'(bus.mem_rdata);
  assign w_last           = r_cnt == CNT_W'(INSTR_BYTES - 1);
  assign bus.mem_addr     = r_pc + ADDR_W'(r_cnt);
  assign bus.instr        = r_instr;
  assign bus.instr_pc     = r_pc;
  assign bus.instr_valid  = r_valid;
  assign bus.halted       = r_halted;
  // next-state: redirect beats everything in FETCH/DECIDE/HALT; WAIT only moves on exec_done
  always_comb begin
    w_state_n  = r_state;
    w_pc_n     = r_pc;
    w_cnt_n    = r_cnt;
    w_instr_n  = r_instr;
    w_valid_n  = r_valid;
    w_halted_n = r_halted;
    case (r_state)
      S_FETCH: begin
        if (bus.redirect_valid) begin
          w_pc_n  = bus.redirect_pc;
          w_cnt_n = '0;
        end else if (bus.fetch_en) begin
          w_instr_n = w_shift;
          w_cnt_n   = w_last ? '0 : r_cnt + 1'b1;
          w_state_n = w_last ? S_DECIDE : S_FETCH;
        end
      end
      S_DECIDE: begin
        if (bus.redirect_valid) begin
          w_pc_n    = bus.redirect_pc;
          w_cnt_n   = '0;
          w_state_n = S_FETCH;
        end else if (HALT_EN && r_instr == '0) begin
          w_halted_n = 1'b1;
          w_state_n  = S_HALT;
        end else begin
          w_valid_n = 1'b1;
          w_state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.exec_done) begin
          w_valid_n = 1'b0;
          w_state_n = S_FETCH;
          w_pc_n    = bus.redirect_valid ? bus.redirect_pc : r_pc + ADDR_W'(INSTR_BYTES);
        end
      end
      default: begin
        if (bus.redirect_valid) begin
          w_pc_n     = bus.redirect_pc;
          w_halted_n = 1'b0;
          w_cnt_n    = '0;
          w_state_n  = S_FETCH;
        end
      end
    endcase
  end
  // state register; reset drops any partial word or pending handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_cnt    <= '0;
      r_instr  <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_pc     <= w_pc_n;
      r_cnt    <= w_cnt_n;
      r_instr  <= w_instr_n;
      r_valid  <= w_valid_n;
      r_halted <= w_halted_n;
    end
  end
endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb_instr_fetch_seq: table-driven check of fetch, handshake, redirect, halt and wrap behaviour
module tb_instr_fetch_seq;
  typedef struct {
    logic        fe, ed, rv;
    logic [18:0] rpc, ma;
    logic        v;
    logic [31:0] ins;
    logic [18:0] ipc;
    logic        h, v1;
    logic [31:0] i1;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [7:0] mem [0:(1<<19)-1];
  vec_t tbl[$];
  instr_fetch_seq_if #(.ADDR_W(19), .BYTE_W(8), .INSTR_BYTES(4)) b0 ();
  instr_fetch_seq_if #(.ADDR_W(19), .BYTE_W(8), .INSTR_BYTES(4)) b1 ();
  instr_fetch_seq #(.HALT_EN(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  instr_fetch_seq #(.HALT_EN(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  assign b0.mem_rdata      = mem[b0.mem_addr];
  assign b1.mem_rdata      = mem[b1.mem_addr];
  assign b1.fetch_en       = b0.fetch_en;
  assign b1.exec_done      = b0.exec_done;
  assign b1.redirect_valid = b0.redirect_valid;
  assign b1.redirect_pc    = b0.redirect_pc;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask
  function automatic void add2(input logic fe, ed, rv, input logic [18:0] rpc, ma, input logic v,
                               input logic [31:0] ins, input logic [18:0] ipc, input logic h,
                               input logic v1, input logic [31:0] i1);
    vec_t t;
    t.fe = fe; t.ed = ed; t.rv = rv; t.rpc = rpc; t.ma = ma; t.v = v;
    t.ins = ins; t.ipc = ipc; t.h = h; t.v1 = v1; t.i1 = i1;
    tbl.push_back(t);
  endfunction
  function automatic void add(input logic fe, ed, rv, input logic [18:0] rpc, ma, input logic v,
                              input logic [31:0] ins, input logic [18:0] ipc);
    add2(fe, ed, rv, rpc, ma, v, ins, ipc, 1'b0, v, ins);
  endfunction
  initial begin
    for (int i = 0; i < (1 << 19); i++) mem[i] = 8'h00;
    {mem[0], mem[1], mem[2], mem[3]}     = 32'h12345678;
    {mem[4], mem[5], mem[6], mem[7]}     = 32'hAABBCCDD;
    {mem[16], mem[17], mem[18], mem[19]} = 32'h9ABCDEF0;
    {mem[32], mem[33], mem[34], mem[35]} = 32'h11223344;
    {mem[19'h7FFFE], mem[19'h7FFFF]}     = 16'h5AA5;
    mem[256] = 8'h01;
    b0.fetch_en = 1'b0; b0.exec_done = 1'b0; b0.redirect_valid = 1'b0; b0.redirect_pc = '0;
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 19'(i), 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 1, 32'h12345678, 0);
    add(0, 1, 0, 0, 0, 1, 32'h12345678, 0);
    add(1, 0, 0, 0, 4, 0, 0, 0);
    add(0, 0, 0, 0, 5, 0, 0, 0);
    add(1, 0, 0, 0, 5, 0, 0, 0);
    add(0, 0, 0, 0, 6, 0, 0, 0);
    add(1, 0, 0, 0, 6, 0, 0, 0);
    add(1, 0, 0, 0, 7, 0, 0, 0);
    add(0, 0, 0, 0, 4, 0, 0, 0);
    add(0, 1, 1, 19'h100, 4, 1, 32'hAABBCCDD, 4);
    add(1, 0, 0, 0, 19'h100, 0, 0, 0);
    add(1, 0, 0, 0, 19'h101, 0, 0, 0);
    add(1, 0, 1, 19'h10, 19'h102, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 19'(16 + i), 0, 0, 0);
    add(1, 0, 0, 0, 19'h10, 0, 0, 0);
    add(0, 1, 1, 8, 19'h10, 1, 32'h9ABCDEF0, 19'h10);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 19'(8 + i), 0, 0, 0);
    add(1, 0, 0, 0, 8, 0, 0, 0);
    add2(1, 0, 0, 0, 8, 0, 0, 0, 1, 1, 0);
    add2(1, 0, 1, 19'h20, 8, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) add2(1, 0, 0, 0, 19'(32 + i), 0, 0, 0, 0, 1, 0);
    add2(0, 0, 0, 0, 19'h20, 0, 0, 0, 0, 1, 0);
    add2(0, 1, 0, 0, 19'h20, 1, 32'h11223344, 19'h20, 0, 1, 0);
    add(0, 0, 1, 19'h7FFFE, 19'h24, 0, 0, 0);
    add(1, 0, 0, 0, 19'h7FFFE, 0, 0, 0);
    add(1, 0, 0, 0, 19'h7FFFF, 0, 0, 0);
    add(1, 0, 0, 0, 19'h00000, 0, 0, 0);
    add(1, 0, 0, 0, 19'h00001, 0, 0, 0);
    add(0, 0, 0, 0, 19'h7FFFE, 0, 0, 0);
    add(0, 1, 0, 0, 19'h7FFFE, 1, 32'h5AA51234, 19'h7FFFE);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 19'(2 + i), 0, 0, 0);
    add(0, 0, 0, 0, 2, 0, 0, 0);
    add(0, 0, 0, 0, 2, 1, 32'h5678AABB, 2);
    #12;
    chk("rst_mem_addr", 32'(b0.mem_addr), 0);
    chk("rst_valid", 32'(b0.instr_valid), 0);
    chk("rst_instr", b0.instr, 0);
    chk("rst_instr_pc", 32'(b0.instr_pc), 0);
    chk("rst_halted", 32'(b0.halted), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      b0.fetch_en = tbl[i].fe; b0.exec_done = tbl[i].ed;
      b0.redirect_valid = tbl[i].rv; b0.redirect_pc = tbl[i].rpc;
      #1;
      chk($sformatf("v%0d_mem_addr", i), 32'(b0.mem_addr), 32'(tbl[i].ma));
      chk($sformatf("v%0d_valid", i), 32'(b0.instr_valid), 32'(tbl[i].v));
      chk($sformatf("v%0d_halted", i), 32'(b0.halted), 32'(tbl[i].h));
      if (tbl[i].v || tbl[i].h) chk($sformatf("v%0d_instr", i), b0.instr, tbl[i].h ? 32'h0 : tbl[i].ins);
      if (tbl[i].v) chk($sformatf("v%0d_instr_pc", i), 32'(b0.instr_pc), 32'(tbl[i].ipc));
      chk($sformatf("v%0d_nohalt_valid", i), 32'(b1.instr_valid), 32'(tbl[i].v1));
      chk($sformatf("v%0d_nohalt_halted", i), 32'(b1.halted), 0);
      if (tbl[i].v1) chk($sformatf("v%0d_nohalt_instr", i), b1.instr, tbl[i].i1);
    end
    @(negedge clk);
    b0.fetch_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midwait_rst_valid", 32'(b0.instr_valid), 0);
    chk("midwait_rst_pc", 32'(b0.instr_pc), 0);
    chk("midwait_rst_mem_addr", 32'(b0.mem_addr), 0);
    chk("midwait_rst_instr", b0.instr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("refetch_not_yet_valid", 32'(b0.instr_valid), 0);
    @(negedge clk);
    #1;
    chk("refetch_valid", 32'(b0.instr_valid), 1);
    chk("refetch_instr", b0.instr, 32'h12345678);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
